// File: rtl/stage_if_pkg.sv
// stage_if_pkg -- shared definitions for the instruction-fetch stage.
//   if_state_t        : fetch FSM states (request / wait for data / have instruction)
//   fromNPC_D         : ctrl_pc_src_D value selecting the decode-stage target
//   fromPCInc4_F      : ctrl_pc_src_D value selecting sequential fetch
//   PC_RESET_DEFAULT  : default reset vector
//   word_align()      : clears the byte-offset bits of an address
package stage_if_pkg;

    typedef enum logic [1:0] {
        IF_S_REQ  = 2'd0,
        IF_S_WAIT = 2'd1,
        IF_S_HAVE = 2'd2
    } if_state_t;

    localparam logic fromNPC_D    = 1'b1;
    localparam logic fromPCInc4_F = 1'b0;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_unit.sv
// if_pc_unit -- program counter, next-PC selection and pending-redirect store.
//   clk, rst_n : clock, asynchronous active-low reset
//   consume    : decode takes the presented instruction; PC advances
//   sample     : a branch left decode while fetch had no instruction to hand over;
//                remember npc until the delay slot is consumed
//   pc_src     : fromNPC_D / fromPCInc4_F
//   npc        : branch/jump target from decode
//   pc         : current fetch PC
//   pc_inc4    : pc + 4 (modulo 2^32)
module if_pc_unit
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        consume,
    input  logic        sample,
    input  logic        pc_src,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic [31:0] pc_inc4
);

    logic        pending;
    logic [31:0] target;
    logic [31:0] next_pc;

    assign pc_inc4 = pc + 32'd4;

    // A stored redirect belongs to a branch that has already left decode, so it
    // takes priority over whatever decode is presenting now.
    always_comb begin
        next_pc = pc_inc4;
        if (pending) begin
            next_pc = target;
        end else if (pc_src == fromNPC_D) begin
            next_pc = npc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            pending <= 1'b0;
            target  <= '0;
        end else if (consume) begin
            pc      <= next_pc;
            pending <= 1'b0;
        end else if (sample) begin
            pending <= 1'b1;
            target  <= npc;
        end
    end

endmodule

// File: rtl/stage_if.sv
// stage_if -- instruction-fetch stage (IF -> ID producer).
// Owns the fetch FSM, the instruction buffer and the instruction-memory port;
// PC handling lives in if_pc_unit.
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall_F           : hold the presented instruction
//   ctrl_pc_src_D     : redirect select from decode
//   NPC_D             : redirect target from decode
//   imem_req/addr     : request valid / word address (held until imem_ready)
//   imem_ready        : request accepted
//   imem_rvalid/rdata : response valid / instruction word
//   IR_F, valid_F     : instruction to decode (0 = bubble) and its valid flag
//   PC_F, PCInc4_F    : PC of the held/fetched instruction and PC + 4
//   adel_F            : misaligned-fetch flag, present only when IF_ADEL_CHECK_EN
//                       is defined
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_F,
    input  logic        ctrl_pc_src_D,
    input  logic [31:0] NPC_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR_F,
    output logic [31:0] PCInc4_F,
    output logic [31:0] PC_F,
    output logic        valid_F
`ifdef IF_ADEL_CHECK_EN
    ,
    output logic        adel_F
`endif
);

    if_state_t   state_q;
    if_state_t   state_d;
    logic [31:0] ibuf;
    logic        consume;
    logic        sample;
    logic        misaligned;

    if_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .consume (consume),
        .sample  (sample),
        .pc_src  (ctrl_pc_src_D),
        .npc     (NPC_D),
        .pc      (PC_F),
        .pc_inc4 (PCInc4_F)
    );

`ifdef IF_ADEL_CHECK_EN
    assign misaligned = |PC_F[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IF_S_REQ: begin
                if (misaligned) begin
                    state_d = IF_S_HAVE;
                end else if (imem_ready) begin
                    state_d = IF_S_WAIT;
                end
            end
            IF_S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = IF_S_HAVE;
                end
            end
            IF_S_HAVE: begin
                if (!stall_F) begin
                    state_d = IF_S_REQ;
                end
            end
            default: state_d = IF_S_REQ;
        endcase
    end

    // Outputs. IR_F/valid_F depend only on registered state and buffer.
    // A redirect seen outside S_HAVE means the branch is leaving decode behind
    // a bubble, so the target must wait for the delay slot still in flight.
    always_comb begin
        imem_req  = (state_q == IF_S_REQ) && !misaligned;
        imem_addr = word_align(PC_F);
        valid_F   = (state_q == IF_S_HAVE);
        IR_F      = (state_q == IF_S_HAVE) ? ibuf : '0;
        consume   = (state_q == IF_S_HAVE) && !stall_F;
        sample    = (state_q != IF_S_HAVE) && !stall_F && (ctrl_pc_src_D == fromNPC_D);
    end

    // Instruction buffer; a faulting slot delivers a nop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibuf <= '0;
        end else if (state_q == IF_S_WAIT && imem_rvalid) begin
            ibuf <= imem_rdata;
        end else if (state_q == IF_S_REQ && misaligned) begin
            ibuf <= '0;
        end
    end

`ifdef IF_ADEL_CHECK_EN
    logic adel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adel_q <= 1'b0;
        end else if (state_q == IF_S_REQ && misaligned) begin
            adel_q <= 1'b1;
        end else if (consume) begin
            adel_q <= 1'b0;
        end
    end

    assign adel_F = adel_q;
`endif

endmodule
